// File: rtl/synth_pkg.sv
// Shared definitions for the voice-path synth blocks.
// - adsr_state_e : ADSR state encoding (IDLE=0 .. RELEASE=4).
// - mid_of()     : offset-binary mid-scale for a given sample width.
// - max_of()     : full-scale unsigned value for a given width (width <= 31).
package synth_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } adsr_state_e;

  function automatic int unsigned mid_of(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  function automatic int unsigned max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/adsr_env_stepper.sv
// ADSR state machine with a saturating envelope register.
// Advances only on cycles where strobe_i is high.
// Ports:
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   strobe_i          : one-cycle sample strobe
//   playing_i         : gate, sampled only on strobe
//   attack_rate_i     : increment per strobe in ATTACK
//   decay_rate_i      : decrement per strobe in DECAY
//   sustain_level_i   : DECAY floor and SUSTAIN level
//   release_rate_i    : decrement per strobe in RELEASE
//   env_o, state_o    : current (registered) envelope and state
module adsr_env_stepper
  import synth_pkg::*;
#(
  parameter int unsigned ENV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 strobe_i,
  input  logic                 playing_i,
  input  logic [ENV_WIDTH-1:0] attack_rate_i,
  input  logic [ENV_WIDTH-1:0] decay_rate_i,
  input  logic [ENV_WIDTH-1:0] sustain_level_i,
  input  logic [ENV_WIDTH-1:0] release_rate_i,
  output logic [ENV_WIDTH-1:0] env_o,
  output adsr_state_e          state_o
);

  localparam logic [ENV_WIDTH-1:0] EnvMax = ENV_WIDTH'(max_of(ENV_WIDTH));

  adsr_state_e          state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH-1:0] decay_diff, release_diff;

  always_comb begin
    state_d      = state_q;
    env_d        = env_q;
    attack_sum   = {1'b0, env_q} + {1'b0, attack_rate_i};
    // Saturating subtracts clamp at zero before any floor is applied.
    decay_diff   = (env_q >= decay_rate_i) ? env_q - decay_rate_i : '0;
    release_diff = (env_q >= release_rate_i) ? env_q - release_rate_i : '0;
    if (strobe_i) begin
      case (state_q)
        StIdle: begin
          env_d = '0;
          if (playing_i) state_d = StAttack;
        end
        StAttack: begin
          if (!playing_i) begin
            state_d = StRelease;
          end else begin
            env_d = attack_sum[ENV_WIDTH] ? EnvMax : attack_sum[ENV_WIDTH-1:0];
            if (env_d == EnvMax) state_d = StDecay;
          end
        end
        StDecay: begin
          if (!playing_i) begin
            state_d = StRelease;
          end else begin
            env_d = (decay_diff < sustain_level_i) ? sustain_level_i : decay_diff;
            if (env_d == sustain_level_i) state_d = StSustain;
          end
        end
        StSustain: begin
          env_d = sustain_level_i;
          if (!playing_i) state_d = StRelease;
        end
        StRelease: begin
          // Retrigger keeps the current level so the attack ramps from there.
          if (playing_i) begin
            state_d = StAttack;
          end else begin
            env_d = release_diff;
            if (release_diff == '0) state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  assign env_o   = env_q;
  assign state_o = state_q;

endmodule

// File: rtl/adsr_envelope_follower.sv
// Clocked ADSR envelope follower for one voice: detects sample strobes, steps
// the envelope, and scales offset-binary samples by envelope x velocity through
// a 2-stage pipeline (output pulse two clocks after each strobe).
// Ports:
//   clk, rstN        : clock, synchronous active-low reset
//   inSample         : offset-binary input sample
//   inSampleReady    : strobe level; rising edge marks a new sample
//   inIsPlaying      : gate (key held)
//   velocity         : note velocity, unsigned
//   attackRate, decayRate, sustainLevel, releaseRate : envelope controls
//   outSample        : scaled offset-binary sample (held between pulses)
//   outSampleReady   : one-clock pulse, outSample valid
//   outState         : current ADSR state
//   outActive        : high when state != IDLE
module adsr_envelope_follower
  import synth_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned VEL_WIDTH = 12,
  parameter int unsigned ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [WIDTH-1:0]     inSample,
  input  logic                 inSampleReady,
  input  logic                 inIsPlaying,
  input  logic [VEL_WIDTH-1:0] velocity,
  input  logic [ENV_WIDTH-1:0] attackRate,
  input  logic [ENV_WIDTH-1:0] decayRate,
  input  logic [ENV_WIDTH-1:0] sustainLevel,
  input  logic [ENV_WIDTH-1:0] releaseRate,
  output logic [WIDTH-1:0]     outSample,
  output logic                 outSampleReady,
  output logic [2:0]           outState,
  output logic                 outActive
);

  localparam logic [WIDTH-1:0] Mid = WIDTH'(mid_of(WIDTH));
  localparam int unsigned EvWidth = ENV_WIDTH + VEL_WIDTH;
  localparam int unsigned PrWidth = WIDTH + ENV_WIDTH + 1;

  logic                 ready_prev_q;
  logic                 strobe;
  logic [ENV_WIDTH-1:0] env;
  adsr_state_e          state;

  logic [EvWidth-1:0]       env_vel;
  logic signed [WIDTH-1:0]  centred_q, centred_d;
  logic [ENV_WIDTH-1:0]     gain_q, gain_d;
  logic                     valid_q;
  logic signed [PrWidth-1:0] prod_full;
  logic [WIDTH-1:0]         out_sample_q, out_sample_d;
  logic                     out_ready_q;
  logic                     unused_bits;

  assign strobe = inSampleReady & ~ready_prev_q;

  adsr_env_stepper #(
    .ENV_WIDTH (ENV_WIDTH)
  ) u_stepper (
    .clk_i           (clk),
    .rst_ni          (rstN),
    .strobe_i        (strobe),
    .playing_i       (inIsPlaying),
    .attack_rate_i   (attackRate),
    .decay_rate_i    (decayRate),
    .sustain_level_i (sustainLevel),
    .release_rate_i  (releaseRate),
    .env_o           (env),
    .state_o         (state)
  );

  always_comb begin
    // Stage 1 uses the pre-step envelope; the stepper updates on the same edge.
    env_vel   = {{VEL_WIDTH{1'b0}}, env} * {{ENV_WIDTH{1'b0}}, velocity};
    gain_d    = env_vel[EvWidth-1:VEL_WIDTH];
    centred_d = $signed(inSample - Mid);
    // Stage 2: the low bits of (centred*gain) >>> ENV_WIDTH are a plain slice.
    prod_full = $signed({{(ENV_WIDTH + 1){centred_q[WIDTH-1]}}, centred_q})
              * $signed({{WIDTH{1'b0}}, 1'b0, gain_q});
    out_sample_d = valid_q ? prod_full[ENV_WIDTH +: WIDTH] + Mid : out_sample_q;
  end

  assign unused_bits = ^{env_vel[VEL_WIDTH-1:0], prod_full[ENV_WIDTH-1:0],
                         prod_full[PrWidth-1:ENV_WIDTH+WIDTH]};

  always_ff @(posedge clk) begin
    if (!rstN) begin
      ready_prev_q <= 1'b0;
      centred_q    <= '0;
      gain_q       <= '0;
      valid_q      <= 1'b0;
      out_sample_q <= Mid;
      out_ready_q  <= 1'b0;
    end else begin
      ready_prev_q <= inSampleReady;
      valid_q      <= strobe;
      out_ready_q  <= valid_q;
      out_sample_q <= out_sample_d;
      if (strobe) begin
        centred_q <= centred_d;
        gain_q    <= gain_d;
      end
    end
  end

  assign outSample      = out_sample_q;
  assign outSampleReady = out_ready_q;
  assign outState       = state;
  assign outActive      = (state != StIdle);

endmodule
